// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA scan-out engine: pixel-rate enable, raster counters, sync
// generation and blanked RGB, all clocked on the single system clock.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RGB_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic             pix_req,
    output logic             pix_tick,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DCNT_W  = $clog2(CLK_DIV);

    localparam logic [DCNT_W-1:0] DCNT_LAST     = DCNT_W'(CLK_DIV - 1);
    localparam logic [DCNT_W-1:0] DCNT_PRE_LAST = DCNT_W'(CLK_DIV - 2);

    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DCNT_W-1:0] dcnt;
    logic [9:0]        hcnt;
    logic [9:0]        vcnt;
    logic              h_last;
    logic              v_last;
    logic              in_active;
    logic              in_hsync;
    logic              in_vsync;
    logic              at_origin;

    assign h_last    = (hcnt == H_LAST);
    assign v_last    = (vcnt == V_LAST);
    assign in_active = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign in_hsync  = (hcnt >= HS_START) && (hcnt < HS_END);
    assign in_vsync  = (vcnt >= VS_START) && (vcnt < VS_END);
    assign at_origin = (hcnt == 10'd0) && (vcnt == 10'd0);

    // pix_tick is registered one count early so it is high exactly while
    // dcnt sits at its last value, giving a jitter-free CLK_DIV period.
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt     <= '0;
            pix_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            dcnt     <= (dcnt == DCNT_LAST) ? '0 : dcnt + DCNT_W'(1);
            pix_tick <= (dcnt == DCNT_PRE_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_tick) begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? 10'd0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    // Connector outputs are computed from the pre-advance coordinate, so they
    // trail pix_x/pix_y by exactly one pixel period.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_tick && at_origin;
            if (pix_tick) begin
                rgb   <= in_active ? rgb_in : '0;
                hsync <= !in_hsync;
                vsync <= !in_vsync;
            end
        end
    end

    assign pix_x   = hcnt;
    assign pix_y   = vcnt;
    assign pix_req = in_active;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: two instances (CLK_DIV 4 with full
// line width, CLK_DIV 2 with a shrunken raster) checked against a tick-index model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    task automatic check(input int lane, input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL lane%0d %s: got %0h expected %0h", lane, tag, got, want);
        end
    endtask

    function automatic logic [11:0] fb_word(input logic [9:0] x, input logic [9:0] y);
        return {y[3:0], x[7:0]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int D     = (g == 0) ? 4 : 2;
        localparam int LAT   = (g == 0) ? 2 : 1;
        localparam int HA    = (g == 0) ? 640 : 20;
        localparam int HF    = (g == 0) ? 16 : 4;
        localparam int HS    = (g == 0) ? 96 : 6;
        localparam int HB    = (g == 0) ? 48 : 4;
        localparam int VA    = (g == 0) ? 4 : 12;
        localparam int VF    = (g == 0) ? 1 : 2;
        localparam int VS    = (g == 0) ? 1 : 2;
        localparam int VB    = (g == 0) ? 1 : 3;
        localparam int HT    = HA + HF + HS + HB;
        localparam int VT    = VA + VF + VS + VB;
        localparam int FRAME = HT * VT;
        localparam logic [11:0] CORNER = (g == 0) ? 12'h37F : 12'hB13;

        logic [11:0] rgb_in   = '0;
        logic [11:0] fb_stage = '0;
        logic [9:0]  pix_x;
        logic [9:0]  pix_y;
        logic        pix_req;
        logic        pix_tick;
        logic        hsync;
        logic        vsync;
        logic [11:0] rgb;
        logic        frame_start;

        vga_timing_gen #(
            .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .RGB_W(12)
        ) dut (
            .clk(clk), .rst(rst), .rgb_in(rgb_in),
            .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req), .pix_tick(pix_tick),
            .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
        );

        // Framebuffer reader model with LAT clocks of read latency.
        always @(negedge clk) begin
            if (LAT == 2) begin
                rgb_in   = fb_stage;
                fb_stage = fb_word(pix_x, pix_y);
            end else begin
                rgb_in = fb_word(pix_x, pix_y);
            end
        end

        int   k = 0;
        bit   in_reset = 1'b1;
        exp_t exp_q[$];
        exp_t cur;
        exp_t e;
        int   p, px, py;
        int   n, pos, ex, ey, op, ox, oy;
        int   tick_cnt, hs_run, vs_run, hs_meas, vs_meas, fs_cnt, last_fs;
        bit   seen_tick, prev_hs, prev_vs;

        // Scoreboard producer: on every tick edge, the expected connector
        // outputs for the coordinate being retired are queued.
        always @(posedge clk) begin
            if (rst) begin
                k = 0;
                in_reset = 1'b1;
                exp_q.delete();
            end else begin
                in_reset = 1'b0;
                k++;
                if (k % D == 0) begin
                    p  = (k / D - 1) % FRAME;
                    px = p % HT;
                    py = p / HT;
                    e.rgb = (px < HA && py < VA) ? fb_word(10'(px), 10'(py)) : 12'h000;
                    e.hs  = !(px >= HA + HF && px < HA + HF + HS);
                    e.vs  = !(py >= VA + VF && py < VA + VF + VS);
                    e.fs  = (p == 0);
                    exp_q.push_back(e);
                end
            end
        end

        always @(negedge clk) begin
            if (in_reset) begin
                check(g, "rst_pix_x", pix_x, 0);
                check(g, "rst_pix_y", pix_y, 0);
                check(g, "rst_pix_req", pix_req, 1);
                check(g, "rst_pix_tick", pix_tick, 0);
                check(g, "rst_hsync", hsync, 1);
                check(g, "rst_vsync", vsync, 1);
                check(g, "rst_rgb", rgb, 0);
                check(g, "rst_frame_start", frame_start, 0);
                cur = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
                tick_cnt = 0; hs_run = 0; vs_run = 0;
                hs_meas = 0; vs_meas = 0; fs_cnt = 0; last_fs = -1;
                seen_tick = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
            end else begin
                n   = k / D;
                pos = n % FRAME;
                ex  = pos % HT;
                ey  = pos / HT;
                check(g, "pix_x", pix_x, ex);
                check(g, "pix_y", pix_y, ey);
                check(g, "pix_req", pix_req, (ex < HA && ey < VA) ? 1 : 0);
                check(g, "pix_tick", pix_tick, (k % D == D - 1) ? 1 : 0);

                if (k <= 1000 && pix_tick) tick_cnt++;
                if (k == 1000) check(g, "tick_count_1000clk", tick_cnt, 1000 / D);
                if (pix_tick && !seen_tick) begin
                    seen_tick = 1'b1;
                    check(g, "first_tick_clk", k, D - 1);
                end

                if (k % D == 0) begin
                    if (exp_q.size() == 0) check(g, "scoreboard_empty", 0, 1);
                    else cur = exp_q.pop_front();
                    check(g, "rgb", rgb, cur.rgb);
                    check(g, "hsync", hsync, cur.hs);
                    check(g, "vsync", vsync, cur.vs);
                    check(g, "frame_start", frame_start, cur.fs);

                    op = (n - 1) % FRAME;
                    ox = op % HT;
                    oy = op / HT;
                    if (ox == 5 && oy == 3) check(g, "rgb_after_5_3", rgb, 12'h305);
                    if (ox == HA - 1 && oy == VA - 1) check(g, "rgb_after_corner", rgb, CORNER);
                    if (ox == HA && oy == 0) check(g, "rgb_after_first_blank", rgb, 0);

                    if (!hsync) hs_run = prev_hs ? 1 : hs_run + 1;
                    if (!hsync && prev_hs) check(g, "hsync_fall_x", ox, HA + HF);
                    if (hsync && !prev_hs) begin
                        check(g, "hsync_width_ticks", hs_run, HS);
                        hs_meas++;
                    end
                    if (!vsync) vs_run = prev_vs ? 1 : vs_run + 1;
                    if (!vsync && prev_vs) begin
                        check(g, "vsync_fall_x", ox, 0);
                        check(g, "vsync_fall_y", oy, VA + VF);
                    end
                    if (vsync && !prev_vs) begin
                        check(g, "vsync_width_ticks", vs_run, VS * HT);
                        vs_meas++;
                    end
                    prev_hs = hsync;
                    prev_vs = vsync;
                end else begin
                    check(g, "rgb_hold", rgb, cur.rgb);
                    check(g, "hsync_hold", hsync, cur.hs);
                    check(g, "vsync_hold", vsync, cur.vs);
                    check(g, "frame_start_low", frame_start, 0);
                end

                if (frame_start) begin
                    if (last_fs < 0) check(g, "first_frame_start_clk", k, D);
                    else check(g, "frame_start_spacing_clk", k - last_fs, D * FRAME);
                    last_fs = k;
                    fs_cnt++;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3000) @(negedge clk);
        // Mid-frame reset; lane 0 is inside its hsync pulse at this point.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (23000) @(negedge clk);

        for (int i = 0; i < 1; i++) begin
            check(0, "hsync_pulse_seen", (lane[0].hs_meas > 0) ? 1 : 0, 1);
            check(0, "vsync_pulse_seen", (lane[0].vs_meas > 0) ? 1 : 0, 1);
            check(0, "frame_starts_seen", (lane[0].fs_cnt >= 2) ? 1 : 0, 1);
            check(1, "hsync_pulse_seen", (lane[1].hs_meas > 0) ? 1 : 0, 1);
            check(1, "vsync_pulse_seen", (lane[1].vs_meas > 0) ? 1 : 0, 1);
            check(1, "frame_starts_seen", (lane[1].fs_cnt >= 2) ? 1 : 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing and scan-out engine for the 640x480@60 VGA output. It is the consumer side of the VGA pixel clock: it generates its own pixel-rate enable on the 100 MHz system clock rather than clocking logic from a divided clock. It produces HSYNC/VSYNC, requests one pixel per pixel period from the framebuffer reader, and drives blanked RGB to the connector pins. All outputs are registered and mutually aligned.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel. Must be ≥ 2.
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal pixel counts. H_TOTAL = 800.
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical line counts. V_TOTAL = 525.
- `RGB_W`, 12: colour width (4:4:4).

Ports:
- `clk` in 1: system clock, 100 MHz. This is the only clock.
- `rst` in 1: synchronous, active-high reset.
- `rgb_in` in RGB_W: pixel data from the framebuffer for the current `pix_x`/`pix_y`.
- `pix_x` out 10: horizontal counter value (hcnt).
- `pix_y` out 10: vertical counter value (vcnt).
- `pix_req` out 1: high when hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- `pix_tick` out 1: one-clk pulse, once every CLK_DIV clks.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `rgb` out RGB_W: colour to the DAC pins.
- `frame_start` out 1: one-clk pulse marking output of pixel (0,0).

## Operation
- Divider `dcnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_tick` is a registered signal, high for the clk in which dcnt == CLK_DIV-1.
- Counters advance only on a clk where `pix_tick` = 1.
  - hcnt: 0..H_TOTAL-1, then wraps to 0.
  - vcnt: increments on an hcnt wrap; wraps 0 after V_TOTAL-1.
  - (799,524) → (0,0) happens in a single tick.
- `pix_x`, `pix_y`, `pix_req` are driven directly from the counter registers, with no extra logic stage.
- Framebuffer handshake:
  - The source sees the new coordinate the clk after a tick.
  - It must hold `rgb_in` valid for that coordinate by the next `pix_tick` clk, giving CLK_DIV-1 clks of read latency.
  - There is no backpressure. The source cannot stall the scan.
- On each `pix_tick` clk, from the pre-advance counter values:
  - `rgb` <= `rgb_in` if `pix_req`, else 0.
  - `hsync` <= 0 if H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC (656..751), else 1.
  - `vsync` <= 0 if V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC (490..491), else 1.
  - `frame_start` <= 1 if hcnt == 0 and vcnt == 0, else 0.
- Between ticks, `rgb`, `hsync` and `vsync` hold their values. `frame_start` drops to 0.
- Net result: the connector outputs for coordinate (x,y) appear one pixel period after that coordinate is presented on `pix_x`/`pix_y`.
- Counter widths: hcnt and vcnt are 10 bits. All comparisons are unsigned against the parameter sums.

## Timing
- Reset values, forced on any clk with `rst` = 1, including mid-frame:
  - dcnt = 0, hcnt = 0, vcnt = 0.
  - `pix_tick` = 0, `frame_start` = 0.
  - `hsync` = 1, `vsync` = 1, `rgb` = 0.
  - Consequently `pix_x` = 0, `pix_y` = 0, `pix_req` = 1.
- After reset release:
  - First `pix_tick` occurs CLK_DIV clks after the first clk with `rst` = 0.
  - On that tick, `frame_start` is loaded with 1 and `rgb` with `rgb_in` for (0,0).
  - Both become visible the following clk.
- `pix_tick` period: exactly CLK_DIV clks, with no jitter.
- Line = 800 ticks = 3200 clks. Frame = 420000 ticks = 1,680,000 clks.
- `hsync` low width: 96 ticks. `vsync` low width: 2 lines = 1600 ticks.
- Reset asserted mid-operation aborts the scan on that clk. No partial sync pulse survives reset.

## Test plan
- Reset check: hold `rst` 3 clks mid-frame, then release.
  - All reset values hold on the clk after the first `rst` clk.
  - First `pix_tick` occurs 4 clks after release.
  - `frame_start` pulses once, 1 clk after that tick.
- Tick cadence: run 1000 clks → exactly 250 `pix_tick` pulses, each 1 clk wide and spaced 4 clks.
- Horizontal timing: count ticks over one line.
  - `hsync` falls on the output following hcnt = 656 and stays low 96 ticks.
  - Line period is 800 ticks.
  - `rgb` = 0 whenever the registered coordinate was ≥ 640.
- Vertical/frame timing: run 2 frames.
  - `vsync` low for 1600 ticks, starting after vcnt = 490.
  - `frame_start` spacing = 1,680,000 clks.
  - Wrap goes (799,524) → (0,0).
- Data path: drive `rgb_in` = {pix_y[3:0], pix_x[7:0]} with 2-clk read latency.
  - `rgb` after coordinate (5,3) = 12'h305.
  - `rgb` after (639,479) = 12'hF7F.
  - `rgb` after (640,0) = 0.
- Parameter variant: CLK_DIV = 2 → tick every 2 clks; all sync widths, measured in ticks, are unchanged.
